// File: rtl/adc_frame_pkg.sv
// Shared definitions for the ADC frame sender: EXEC_STATE encodings, header
// magic and field offsets, capture FSM state type.
package adc_frame_pkg;
   localparam logic [1:0]  EXEC_INIT = 2'b00;
   localparam logic [1:0]  EXEC_TRG  = 2'b11;
   localparam logic [15:0] HDR_MAGIC = 16'h5A5A;

   // header beat layout (LSB of each field)
   localparam int HDR_MAGIC_LSB = 112;
   localparam int HDR_TS_LSB    = 64;
   localparam int HDR_FCNT_LSB  = 32;
   localparam int HDR_BL_LSB    = 0;

   typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_CAPTURE} state_t;
endpackage

// File: rtl/adc_frame_sender_if.sv
// AXI4-Stream bus bundle used for the frame output toward the DMA.
//   tdata/tvalid/tlast : driven by the master
//   tready             : driven by the slave
interface adc_frame_sender_if #(parameter int DW = 128);
   logic [DW-1:0] tdata;
   logic          tvalid;
   logic          tready;
   logic          tlast;

   modport master (output tdata, tvalid, tlast, input tready);
   modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
//   clk, rst_n : clock, async active-low reset (flushes pointers/count)
//   push/wdata : write side; a push while full is accepted only with a pop
//   pop        : read side; ignored while empty
//   rdata      : head entry (valid while !empty)
//   count/full/empty : occupancy
module axis_sync_fifo #(
   parameter  int WIDTH = 129,
   parameter  int DEPTH = 64,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic [AW:0]      count,
   output logic             full,
   output logic             empty
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic             do_push, do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk)
      if (do_push) mem[wr_ptr] <= wdata;

   // DEPTH is a power of two, so pointers wrap naturally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/adc_frame_sender.sv
// ADC frame sender: compares every lane of the ADC stream against
// baseline+THRESHOLD_VAL and, on a trigger, queues one header beat plus
// FRAME_LEN data beats (TLAST on the last) into a FWFT FIFO feeding M_AXIS.
// Ports:
//   AXIS_ACLK, AXIS_ARESETN      : clock, async active-low reset
//   EXEC_STATE                   : arms only in TRG (2'b11)
//   I_BASELINE, I_BASELINE_VALID : signed baseline and its valid flag
//   S_AXIS_TDATA, S_AXIS_TVALID  : ADC beats (source cannot stall)
//   M_AXIS                       : AXI4-Stream master (tdata/tvalid/tlast/tready)
//   O_FRAME_CNT, O_DROP_CNT      : completed frames, dropped triggers (saturating)
//   O_BUSY                       : capture in progress
// Build option: BASELINE_SUBTRACT_EN makes data lanes carry sample-baseline
// (sign-extended to 16 bits) instead of the raw lane.
module adc_frame_sender
   import adc_frame_pkg::*;
#(
   parameter int ADC_RESOLUTION_WIDTH = 12,
   parameter int TDATA_WIDTH          = 128,
   parameter int THRESHOLD_VAL        = 410,
   parameter int FRAME_LEN            = 16,
   parameter int FIFO_DEPTH           = 64
) (
   input  logic                            AXIS_ACLK,
   input  logic                            AXIS_ARESETN,
   input  logic [1:0]                      EXEC_STATE,
   input  logic [ADC_RESOLUTION_WIDTH-1:0] I_BASELINE,
   input  logic                            I_BASELINE_VALID,
   input  logic [TDATA_WIDTH-1:0]          S_AXIS_TDATA,
   input  logic                            S_AXIS_TVALID,
   adc_frame_sender_if.master              M_AXIS,
   output logic [31:0]                     O_FRAME_CNT,
   output logic [15:0]                     O_DROP_CNT,
   output logic                            O_BUSY
);
   localparam int RW    = ADC_RESOLUTION_WIDTH;
   localparam int LANES = TDATA_WIDTH / 16;
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int FW    = TDATA_WIDTH + 1;
   localparam int BW    = $clog2(FRAME_LEN + 1);

   state_t                 state, state_nxt;
   logic [47:0]            ts;
   logic [TDATA_WIDTH-1:0] din_q, lane_data, hdr;
   logic                   din_vld_q;
   logic [BW-1:0]          beat_cnt;
   logic [31:0]            frame_cnt;
   logic [15:0]            drop_cnt;
   logic [LANES-1:0]       lane_hit;
   logic                   arm, trig, room, last, done, drop;
   logic                   push, pop;
   logic [FW-1:0]          wdata, rdata;
   logic [AW:0]            fifo_count;
   logic                   fifo_empty;

   // per-lane 13-bit signed compare and data lane formatting
   for (genvar g = 0; g < LANES; g++) begin : g_lane
      logic signed [RW:0] diff;
      assign diff = $signed({S_AXIS_TDATA[g*16+RW-1], S_AXIS_TDATA[g*16 +: RW]})
                  - $signed({I_BASELINE[RW-1], I_BASELINE});
      assign lane_hit[g] = diff > $signed((RW+1)'(THRESHOLD_VAL));
`ifdef BASELINE_SUBTRACT_EN
      assign lane_data[g*16 +: 16] = {{(15-RW){diff[RW]}}, diff};
`else
      assign lane_data[g*16 +: 16] = S_AXIS_TDATA[g*16 +: 16];
`endif
   end

   assign arm  = (EXEC_STATE == EXEC_TRG) && I_BASELINE_VALID;
   assign trig = S_AXIS_TVALID && (|lane_hit);
   assign pop  = !fifo_empty && M_AXIS.tready;
   // free space includes the entry leaving this cycle
   assign room = (int'(FIFO_DEPTH) - int'(fifo_count) + int'(pop)) >= FRAME_LEN + 1;
   assign last = (beat_cnt == BW'(FRAME_LEN - 1));

   always_comb begin
      hdr = '0;
      hdr[HDR_MAGIC_LSB +: 16] = HDR_MAGIC;
      hdr[HDR_TS_LSB    +: 48] = ts;
      hdr[HDR_FCNT_LSB  +: 32] = frame_cnt;
      hdr[HDR_BL_LSB    +: RW] = I_BASELINE;
   end

   always_comb begin
      state_nxt = state;
      push      = 1'b0;
      wdata     = {1'b0, hdr};
      done      = 1'b0;
      drop      = 1'b0;
      case (state)
         ST_IDLE:
            if (arm) state_nxt = ST_ARMED;
         ST_ARMED:
            if (!arm) state_nxt = ST_IDLE;
            else if (trig) begin
               if (room) begin
                  push      = 1'b1;
                  state_nxt = ST_CAPTURE;
               end else begin
                  drop = 1'b1;
               end
            end
         ST_CAPTURE:
            // the delay register lines the trigger beat up right behind the header
            if (din_vld_q) begin
               push  = 1'b1;
               wdata = {last, din_q};
               if (last) begin
                  done      = 1'b1;
                  state_nxt = arm ? ST_ARMED : ST_IDLE;
               end
            end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
      if (!AXIS_ARESETN) begin
         state     <= ST_IDLE;
         ts        <= '0;
         din_q     <= '0;
         din_vld_q <= 1'b0;
         beat_cnt  <= '0;
         frame_cnt <= '0;
         drop_cnt  <= '0;
      end else begin
         state     <= state_nxt;
         ts        <= ts + 48'd1;
         din_q     <= lane_data;
         din_vld_q <= S_AXIS_TVALID;
         if (state == ST_CAPTURE && din_vld_q)
            beat_cnt <= last ? '0 : beat_cnt + 1'b1;
         if (done) frame_cnt <= frame_cnt + 32'd1;
         if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
   end

   axis_sync_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (AXIS_ACLK),
      .rst_n (AXIS_ARESETN),
      .push  (push),
      .wdata (wdata),
      .pop   (pop),
      .rdata (rdata),
      .count (fifo_count),
      .full  (),
      .empty (fifo_empty)
   );

   // idle bus reads as zero rather than stale RAM contents
   assign M_AXIS.tvalid = !fifo_empty;
   assign {M_AXIS.tlast, M_AXIS.tdata} = fifo_empty ? '0 : rdata;

   assign O_FRAME_CNT = frame_cnt;
   assign O_DROP_CNT  = drop_cnt;
   assign O_BUSY      = (state == ST_CAPTURE);
endmodule

// File: tb/tb_adc_frame_sender.sv
// Self-checking bench for adc_frame_sender: directed scenarios with random
// background ADC data, checked every cycle against a frame-level model that
// keeps the expected M_AXIS beat stream in a queue.
module tb_adc_frame_sender;
   logic         clk = 1'b0;
   logic         rst_n;
   logic [1:0]   exec;
   logic [11:0]  bl;
   logic         blv;
   logic [127:0] sdata;
   logic         svalid;
   logic [31:0]  frame_cnt;
   logic [15:0]  drop_cnt;
   logic         busy;

   int vecs = 0;
   int errs = 0;

   adc_frame_sender_if #(.DW(128)) m_axis ();

   adc_frame_sender dut (
      .AXIS_ACLK        (clk),
      .AXIS_ARESETN     (rst_n),
      .EXEC_STATE       (exec),
      .I_BASELINE       (bl),
      .I_BASELINE_VALID (blv),
      .S_AXIS_TDATA     (sdata),
      .S_AXIS_TVALID    (svalid),
      .M_AXIS           (m_axis),
      .O_FRAME_CNT      (frame_cnt),
      .O_DROP_CNT       (drop_cnt),
      .O_BUSY           (busy)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [128:0] q[$];
   int           m_left;     // data beats still owed to the open frame
   bit           m_armed;
   logic [31:0]  m_frames;
   logic [15:0]  m_drops;
   logic [47:0]  m_ts;
   logic [127:0] m_pd;       // previous beat (as it will appear on the bus)
   bit           m_pv;

   function automatic int lane_diff(logic [127:0] d, int i, logic [11:0] b);
      logic signed [11:0] s, bs;
      s  = d[i*16 +: 12];
      bs = b;
      return int'(s) - int'(bs);
   endfunction

   function automatic bit hits(logic [127:0] d);
      for (int i = 0; i < 8; i++)
         if (lane_diff(d, i, bl) > 410) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [127:0] bus_lanes(logic [127:0] d);
      logic [127:0] r;
      r = d;
`ifdef BASELINE_SUBTRACT_EN
      for (int i = 0; i < 8; i++) r[i*16 +: 16] = 16'(lane_diff(d, i, bl));
`endif
      return r;
   endfunction

   function automatic logic [127:0] quiet();
      logic [127:0] d;
      logic [15:0]  v;
      for (int i = 0; i < 8; i++) begin
         v = 16'($urandom);
         d[i*16 +: 16] = v;
         if (lane_diff(d, i, bl) > 410) d[i*16 +: 12] = bl;
      end
      return d;
   endfunction

   task automatic model_reset();
      q.delete();
      m_left = 0; m_armed = 0; m_frames = '0; m_drops = '0;
      m_ts = '0; m_pd = '0; m_pv = 0;
   endtask

   task automatic model_step();
      bit           pop, arm, do_push;
      int           free;
      logic [128:0] pv;
      pop     = (q.size() > 0) && m_axis.tready;
      arm     = (exec == 2'b11) && blv;
      free    = 64 - q.size() + int'(pop);
      do_push = 0;
      pv      = '0;
      if (m_left > 0) begin
         if (m_pv) begin
            pv = {(m_left == 1), m_pd};
            do_push = 1;
            m_left--;
            if (m_left == 0) begin
               m_frames++;
               m_armed = arm;
            end
         end
      end else if (m_armed) begin
         if (!arm) m_armed = 0;
         else if (svalid && hits(sdata)) begin
            if (free >= 17) begin
               pv = {1'b0, 16'h5A5A, m_ts, m_frames, 20'h0, bl};
               do_push = 1;
               m_left = 16;
            end else if (m_drops != 16'hFFFF) m_drops++;
         end
      end else if (arm) m_armed = 1;
      if (pop) q.delete(0);
      if (do_push) q.push_back(pv);
      m_pd = bus_lanes(sdata);
      m_pv = svalid;
      m_ts++;
   endtask

   // ---------------- checking ----------------
   task automatic chk(string tag, logic [128:0] obs, logic [128:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("tvalid", 129'(m_axis.tvalid), 129'(q.size() > 0));
      if (q.size() > 0) chk("beat", {m_axis.tlast, m_axis.tdata}, q[0]);
      chk("frame_cnt", 129'(frame_cnt), 129'(m_frames));
      chk("drop_cnt", 129'(drop_cnt), 129'(m_drops));
      chk("busy", 129'(busy), 129'(m_left > 0));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
   endtask

   task automatic quiet_ticks(int n);
      for (int i = 0; i < n; i++) begin
         sdata = quiet(); svalid = 1'b1;
         tick();
      end
   endtask

   task automatic trigger_tick(logic [15:0] v);
      sdata = quiet();
      sdata[3*16 +: 16] = v;
      svalid = 1'b1;
      tick();
   endtask

   int pops, tlasts;

   initial begin
      rst_n = 1'b0; exec = 2'b00; bl = 12'd100; blv = 1'b0;
      sdata = '0; svalid = 1'b0; m_axis.tready = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_tdata", {m_axis.tlast, m_axis.tdata}, '0);
      check_all();
      rst_n = 1'b1;

      // 1: basic frame, lane3=600 on baseline 100
      exec = 2'b11; blv = 1'b1;
      quiet_ticks(3);
      trigger_tick(16'd600);
      quiet_ticks(20);
      chk("t1_frames", 129'(frame_cnt), 129'(1));

      // 2: threshold boundary, diff==410 does not trigger, 411 does
      trigger_tick(16'd510);
      chk("t2_510_idle", 129'(busy), 129'(0));
      quiet_ticks(3);
      trigger_tick(16'd511);
      chk("t2_511_busy", 129'(busy), 129'(1));
      quiet_ticks(20);

      // 3: full backpressure, 4 triggers 20 beats apart -> 3 frames + 1 drop
      m_axis.tready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         trigger_tick(16'd600);
         quiet_ticks(19);
      end
      quiet_ticks(5);
      chk("t3_frames", 129'(frame_cnt), 129'(5));
      chk("t3_drops", 129'(drop_cnt), 129'(1));
      m_axis.tready = 1'b1;
      pops = 0; tlasts = 0;
      for (int i = 0; i < 70; i++) begin
         if (m_axis.tvalid) begin
            pops++;
            if (m_axis.tlast) tlasts++;
         end
         sdata = quiet(); svalid = 1'b1;
         tick();
      end
      chk("t3_drain_beats", 129'(pops), 129'(51));
      chk("t3_drain_tlast", 129'(tlasts), 129'(3));

      // 4: gapped input during capture, random backpressure
      trigger_tick(16'd700);
      for (int i = 0; i < 40; i++) begin
         sdata = quiet(); svalid = 1'($urandom);
         m_axis.tready = 1'($urandom);
         tick();
      end
      m_axis.tready = 1'b1;
      quiet_ticks(40);
      chk("t4_frames", 129'(frame_cnt), 129'(6));

      // 5: EXEC_STATE leaves TRG mid-frame; frame completes, new trigger ignored
      trigger_tick(16'd650);
      quiet_ticks(5);
      exec = 2'b00;
      quiet_ticks(15);
      trigger_tick(16'd900);
      quiet_ticks(5);
      chk("t5_frames", 129'(frame_cnt), 129'(7));
      chk("t5_idle", 129'(busy), 129'(0));
      exec = 2'b11;
      quiet_ticks(3);

      // 6: reset mid-frame
      trigger_tick(16'd600);
      quiet_ticks(8);
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("t6_rst_tvalid", 129'(m_axis.tvalid), 129'(0));
      chk("t6_rst_frames", 129'(frame_cnt), 129'(0));
      chk("t6_rst_busy", 129'(busy), 129'(0));
      @(negedge clk);
      rst_n = 1'b1;
      quiet_ticks(5);
      trigger_tick(16'd600);
      quiet_ticks(20);
      chk("t6_frames", 129'(frame_cnt), 129'(1));

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
